// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer: control-flow mode encodings
// and the default sequential increment.
package pc_pkg;

  typedef enum logic [1:0] {
    MODE_SEQ    = 2'b00,
    MODE_BRANCH = 2'b01,
    MODE_JUMP   = 2'b10,
    MODE_RET    = 2'b11
  } mode_e;

  localparam int DEFAULT_INC = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. When full, a push overwrites the oldest
// entry. Push and pop together replace the top entry. Error flags are sticky.
module ras_stack #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full,
  output logic            ovf,
  output logic            unf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] top_ptr, ptr_next, wr_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic             wr_en, ovf_set, unf_set;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign top   = mem[top_ptr];

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    wr_en      = 1'b0;
    wr_ptr     = top_ptr + 1'b1;
    ptr_next   = top_ptr;
    count_next = count;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    if (pop) begin
      if (empty) begin
        unf_set = 1'b1;
      end else if (!push) begin
        ptr_next   = top_ptr - 1'b1;
        count_next = count - 1'b1;
      end
    end
    if (push) begin
      wr_en = 1'b1;
      if (pop && !empty) begin
        wr_ptr = top_ptr;
      end else begin
        ptr_next = top_ptr + 1'b1;
        if (full) ovf_set = 1'b1;
        else      count_next = count + 1'b1;
      end
    end
  end

  // NOTE: the storage array is not reset. Count gates every read, so stale data is never used.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_ptr <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      top_ptr <= ptr_next;
      count   <= count_next;
      if (ovf_set) ovf <= 1'b1;
      if (unf_set) unf <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer. It selects the next PC by priority
// (trap > ret > jump > taken branch > sequential) and uses a return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0000),
  parameter int              INC       = DEFAULT_INC,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            advance,
  input  logic            stall,
  input  logic [1:0]      mode,
  input  logic            taken,
  input  logic [XLEN-1:0] offset,
  input  logic [XLEN-1:0] target,
  input  logic            call,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_prev,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_ovf,
  output logic            ras_unf,
  output logic            misalign
);

  mode_e           mode_sel;
  logic            step, redirect, do_push, do_pop;
  logic [XLEN-1:0] ras_top, raw_next, pc_next;

  assign mode_sel = mode_e'(mode);
  assign step     = advance && !stall;
  assign do_push  = step && call && !trap;
  assign do_pop   = step && !trap && (mode_sel == MODE_RET);

  always_comb begin
    redirect = 1'b1;
    raw_next = pc + XLEN'(INC);
    if (trap) begin
      raw_next = trap_vec;
    end else begin
      case (mode_sel)
        MODE_RET:    raw_next = ras_empty ? RESET_VEC : ras_top;
        MODE_JUMP:   raw_next = target;
        MODE_BRANCH: if (taken) raw_next = pc + offset;
                     else       redirect = 1'b0;
        default:     redirect = 1'b0;
      endcase
    end
    // Redirect destinations are forced to word alignment. Sequential steps are left as they are.
    pc_next = redirect ? {raw_next[XLEN-1:2], 2'b00} : raw_next;
  end

  // NOTE: non-blocking assignments let pc_prev capture the pc value from before this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_VEC;
      pc_prev  <= RESET_VEC;
      misalign <= 1'b0;
    end else begin
      misalign <= step && redirect && (raw_next[1:0] != 2'b00);
      if (step) begin
        pc_prev <= pc;
        pc      <= pc_next;
      end
    end
  end

  ras_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (reset),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (pc + XLEN'(INC)),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer using the default parameters
// (XLEN=32, RESET_VEC=0, INC=4, RAS_DEPTH=4).
module tb_pc_sequencer;

  localparam logic [1:0] SEQ = 2'b00, BR = 2'b01, JMP = 2'b10, RET = 2'b11;

  logic        clk = 1'b0;
  logic        reset, advance, stall, taken, call, trap;
  logic [1:0]  mode;
  logic [31:0] offset, target, trap_vec, pc, pc_prev;
  logic        ras_empty, ras_full, ras_ovf, ras_unf, misalign;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .advance   (advance),
    .stall     (stall),
    .mode      (mode),
    .taken     (taken),
    .offset    (offset),
    .target    (target),
    .call      (call),
    .trap      (trap),
    .trap_vec  (trap_vec),
    .pc        (pc),
    .pc_prev   (pc_prev),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf),
    .misalign  (misalign)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic go(input logic [1:0] m, input logic [31:0] tgt = 32'h0,
                    input logic cl = 1'b0, input logic tk = 1'b0,
                    input logic [31:0] off = 32'h0, input logic tr = 1'b0,
                    input logic [31:0] tv = 32'h0, input logic adv = 1'b1,
                    input logic st = 1'b0);
    mode = m; target = tgt; call = cl; taken = tk; offset = off;
    trap = tr; trap_vec = tv; advance = adv; stall = st;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] call_tgt [5];
    logic [31:0] ret_exp  [4];
    call_tgt = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h5000};
    ret_exp  = '{32'h4004, 32'h3004, 32'h2004, 32'h1004};

    reset = 1'b0; advance = 1'b0; stall = 1'b0; mode = SEQ; taken = 1'b0;
    call = 1'b0; trap = 1'b0; offset = '0; target = '0; trap_vec = '0;

    #2;
    check("rst_pc", pc, 32'h0);
    check("rst_pc_prev", pc_prev, 32'h0);
    check("rst_empty", ras_empty, 1);
    check("rst_full", ras_full, 0);
    check("rst_ovf", ras_ovf, 0);
    check("rst_unf", ras_unf, 0);
    check("rst_misalign", misalign, 0);
    #10 reset = 1'b1;
    check("post_rst_pc", pc, 32'h0);

    // Sequential steps, with pc_prev trailing by one step.
    go(SEQ); check("seq1_pc", pc, 32'h4); check("seq1_prev", pc_prev, 32'h0);
    go(SEQ); check("seq2_pc", pc, 32'h8); check("seq2_prev", pc_prev, 32'h4);
    go(SEQ); check("seq3_pc", pc, 32'hC); check("seq3_prev", pc_prev, 32'h8);

    // No step is accepted when advance is low or when stall is high.
    go(SEQ, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0); check("noadv_pc", pc, 32'hC);
    go(SEQ, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1); check("stall_pc", pc, 32'hC);
    check("stall_prev", pc_prev, 32'h8);

    // Branch taken and not taken.
    go(JMP, 32'h100); check("jmp100", pc, 32'h100);
    go(BR, 0, 0, 1, 32'hFFFF_FFF8); check("br_taken", pc, 32'hF8);
    check("br_taken_mis", misalign, 0);
    go(JMP, 32'h100);
    go(BR, 0, 0, 0, 32'hFFFF_FFF8); check("br_not_taken", pc, 32'h104);

    // Call followed by return.
    go(JMP, 32'h200);
    go(JMP, 32'h300, 1); check("call_pc", pc, 32'h300); check("call_nonempty", ras_empty, 0);
    go(RET); check("ret_pc", pc, 32'h204); check("ret_empty", ras_empty, 1);
    check("ret_prev", pc_prev, 32'h300);

    // Five calls into a four-deep stack.
    for (int i = 0; i < 5; i++) begin
      go(JMP, call_tgt[i], 1);
      if (i == 3) begin
        check("full4", ras_full, 1); check("ovf4", ras_ovf, 0);
      end
    end
    check("full5", ras_full, 1); check("ovf5", ras_ovf, 1);
    for (int i = 0; i < 4; i++) begin
      go(RET); check($sformatf("ret_ovf%0d", i), pc, ret_exp[i]);
    end
    check("drained_empty", ras_empty, 1); check("drained_full", ras_full, 0);
    go(RET); check("unf_pc", pc, 32'h0); check("unf_flag", ras_unf, 1);
    check("unf_empty", ras_empty, 1); check("ovf_sticky", ras_ovf, 1);

    // Silent wrap-around of the sequential add.
    go(JMP, 32'hFFFF_FFFC);
    go(SEQ); check("wrap_pc", pc, 32'h0);

    // A stalled trap has no effect; the trap is taken once the stall is released.
    go(JMP, 32'h400);
    go(SEQ, 0, 0, 0, 0, 1, 32'h800, 1'b1, 1'b1); check("trap_stall", pc, 32'h400);
    go(SEQ, 0, 0, 0, 0, 1, 32'h800); check("trap_pc", pc, 32'h800);
    check("trap_prev", pc_prev, 32'h400);

    // A trap suppresses both the push and the pop, even when RET and call are asserted.
    go(JMP, 32'h900, 1); check("push_804", ras_empty, 0);
    go(RET, 0, 1, 0, 0, 1, 32'hA00); check("trap_ret_pc", pc, 32'hA00);
    go(RET); check("trap_kept_top", pc, 32'h804); check("trap_kept_empty", ras_empty, 1);

    // Call together with RET replaces the top entry.
    go(JMP, 32'hB00, 1);
    go(RET, 0, 1); check("replace_pc", pc, 32'h808); check("replace_depth", ras_empty, 0);
    go(RET); check("replace_top", pc, 32'hB04); check("replace_empty", ras_empty, 1);

    // Misaligned redirects are aligned, and misalign pulses for one cycle.
    go(JMP, 32'h303); check("mis_pc", pc, 32'h300); check("mis_pulse", misalign, 1);
    go(SEQ); check("mis_seq_pc", pc, 32'h304); check("mis_clear", misalign, 0);
    go(SEQ, 0, 0, 0, 0, 1, 32'h502); check("mis_trap_pc", pc, 32'h500);
    check("mis_trap_pulse", misalign, 1);
    go(SEQ, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0); check("mis_hold_clear", misalign, 0);

    // Asynchronous reset asserted between clock edges.
    #2 reset = 1'b0;
    #1;
    check("async_pc", pc, 32'h0); check("async_prev", pc_prev, 32'h0);
    check("async_empty", ras_empty, 1); check("async_ovf", ras_ovf, 0);
    check("async_unf", ras_unf, 0);
    #1 reset = 1'b1;
    go(SEQ); check("after_rst_pc", pc, 32'h4); check("after_rst_prev", pc_prev, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC/target width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-003 SHALL have parameter INC, default 4, meaning the sequential PC increment in bytes.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, meaning the return-address stack entry count (power of 2, at least 2).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port advance, input, 1 bit: memory-ready/step enable; the PC updates only when high.
REQ-008 SHALL have port stall, input, 1 bit: pipeline hold; overrides advance.
REQ-009 SHALL have port mode, input, 2 bits: 00 SEQ, 01 BRANCH, 10 JUMP, 11 RET.
REQ-010 SHALL have port taken, input, 1 bit: branch condition, used in BRANCH mode only.
REQ-011 SHALL have port offset, input, XLEN bits: signed branch offset.
REQ-012 SHALL have port target, input, XLEN bits: absolute jump target.
REQ-013 SHALL have port call, input, 1 bit: push the return address PC+INC on this step.
REQ-014 SHALL have port trap, input, 1 bit, and port trap_vec, input, XLEN bits: highest-priority redirect.
REQ-015 SHALL have port pc, output, XLEN bits: current PC.
REQ-016 SHALL have port pc_prev, output, XLEN bits: PC before the last accepted step.
REQ-017 SHALL have ports ras_empty and ras_full, output, 1 bit each: stack status.
REQ-018 SHALL have ports ras_ovf and ras_unf, output, 1 bit each: sticky overflow and underflow error flags.
REQ-019 SHALL have port misalign, output, 1 bit: one-cycle pulse for a non-aligned redirect.

Function
REQ-020 A step SHALL be accepted when advance=1 and stall=0; otherwise pc, pc_prev and the RAS SHALL hold.
REQ-021 Next-PC priority on an accepted step SHALL be: trap gives trap_vec; else RET gives the RAS top; else JUMP gives target; else BRANCH with taken=1 gives pc+offset; else pc+INC.
REQ-022 All additions SHALL be modulo 2^XLEN; wrap-around SHALL be silent.
REQ-023 On every accepted step, pc_prev SHALL take the old pc.
REQ-024 A redirect value whose bits [1:0] are nonzero SHALL load with bits [1:0] cleared and SHALL pulse misalign for exactly one cycle (registered, same edge as the PC update).
REQ-025 A call on an accepted step SHALL push the old pc+INC; trap SHALL suppress both push and pop.
REQ-026 RET on an accepted step SHALL pop; call together with RET SHALL replace the top entry (pop then push; depth unchanged).
REQ-027 A push when full SHALL overwrite the oldest entry (circular), keep the count at RAS_DEPTH, and set ras_ovf.
REQ-028 RET when empty SHALL load RESET_VEC, leave the count at 0, and set ras_unf.
REQ-029 ras_ovf and ras_unf SHALL clear only on reset.
REQ-030 Latency SHALL be one cycle from an accepted step to the new pc on the output.

Reset
REQ-031 When reset=0, asynchronously: pc=RESET_VEC, pc_prev=RESET_VEC, RAS count=0, ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0, misalign=0.
REQ-032 Reset deassertion mid-operation SHALL need no special handling; the first accepted step after reset is taken from RESET_VEC.

Structure
REQ-033 Mode encodings (SEQ/BRANCH/JUMP/RET) and the default INC SHALL live in the shared package pc_pkg.
REQ-034 The return-address stack SHALL be a sub-module ras_stack (circular buffer with top pointer, count, push/pop/replace); next-PC selection stays in pc_sequencer.

Verification
REQ-035 Reset, then 3 SEQ steps -> pc = 0x0, 0x4, 0x8, 0xC; pc_prev lags by one step.
REQ-036 pc=0x100, BRANCH taken with offset=-8 -> pc=0xF8; with taken=0 -> pc=0x104.
REQ-037 pc=0x200, JUMP target=0x300 with call=1, then RET -> pc=0x300, then 0x204; ras_empty=1 afterwards.
REQ-038 5 calls with RAS_DEPTH=4 -> ras_full=1 and ras_ovf=1; 4 RETs return the 4 newest addresses; a 5th RET -> pc=RESET_VEC and ras_unf=1.
REQ-039 stall=1 with trap=1 -> no change; then stall=0 -> pc=trap_vec; target=0x303 -> pc=0x300 and misalign pulses for one cycle.
REQ-040 reset asserted between edges mid-sequence -> outputs reach reset values immediately, without waiting for a clock edge.
